regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 89 ++++++++
 tb/tb_regfile_sb.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port register file with scoreboard busy bits
// Clears every entry after reset, then serves bypassed reads and tracks pending writes.
module regfile_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DW-1:0]     wd,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic [NRP*AW-1:0] ra,
  output logic [NRP*DW-1:0] rd,
  output logic [NRP-1:0]    rbusy,
  output logic              werr
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   cnt, cnt_nx;
  logic [DW-1:0]   mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic            run;
  logic            wr_en;
  logic            iss_ok;

  assign run    = (state == RUN);
  assign wr_en  = run && we && !((ZERO_REG != 0) && (wa == '0));
  assign iss_ok = run && iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ready    = run;
    if (state == CLEAR) begin
      cnt_nx = cnt + 1'b1;
      if (cnt == AW'(DEPTH - 1)) state_nx = RUN;
    end
  end

  // Storage has no reset; the clear sweep defines every entry before ready rises.
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[cnt] <= '0;
    else if (wr_en)     mem[wa]  <= wd;
  end

  // The reservation is assigned last so a same-cycle issue beats the write's clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      werr <= 1'b0;
    end else if (state == CLEAR) begin
      busy[cnt] <= 1'b0;
    end else begin
      if (wr_en && !busy[wa]) werr <= 1'b1;
      if (wr_en)  busy[wa]       <= 1'b0;
      if (iss_ok) busy[iss_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRP; k++) begin : g_rp
    logic [AW-1:0] addr;
    logic          is_zero;
    assign addr    = ra[k*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign rd[k*DW +: DW] = (!run || is_zero)        ? '0 :
                            (wr_en && (wa == addr)) ? wd : mem[addr];
    assign rbusy[k] = run && !is_zero && busy[addr];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
// Scenario tasks drive inputs and compare outputs against hand-computed values.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic        werr;

  int checks = 0;
  int passes = 0;
  int cycles;

  regfile_sb #(.DW(32), .AW(5), .NRP(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .we(we), .wa(wa), .wd(wd),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .ra(ra), .rd(rd), .rbusy(rbusy), .werr(werr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    cycles = 0;
    while (!ready && cycles < 100) begin
      tick();
      cycles++;
      if (ready) begin
        we = 1'b0;
        iss_en = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0;
    iss_en = 1'b0; iss_addr = '0; ra = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready); else passes++;
    checks++; if (werr !== 1'b0) $display("FAIL reset_werr got=%b exp=0", werr); else passes++;
    checks++; if (rd !== 64'd0) $display("FAIL reset_rd got=%h exp=0", rd); else passes++;
    checks++; if (rbusy !== 2'b00) $display("FAIL reset_rbusy got=%b exp=00", rbusy); else passes++;
  endtask

  task automatic test_clear_ignored();
    tick();
    rst_n = 1'b1;
    we = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF;
    iss_en = 1'b1; iss_addr = 5'd3;
    ra = {5'd3, 5'd3};
    #1;
    checks++; if (rd !== 64'd0) $display("FAIL clear_rd got=%h exp=0", rd); else passes++;
    wait_ready();
    checks++; if (cycles !== 32) $display("FAIL clear_len got=%0d exp=32", cycles); else passes++;
    ra = {5'd0, 5'd3};
    #1;
    checks++; if (rd[31:0] !== 32'd0) $display("FAIL clear_wr_ignored got=%h exp=0", rd[31:0]); else passes++;
    checks++; if (werr !== 1'b0) $display("FAIL clear_werr got=%b exp=0", werr); else passes++;
    checks++; if (rbusy !== 2'b00) $display("FAIL clear_iss_ignored got=%b exp=00", rbusy); else passes++;
  endtask

  task automatic test_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      ra = {5'(31 - a), 5'(a)};
      #1;
      checks++;
      if (rd !== 64'd0 || rbusy !== 2'b00)
        $display("FAIL %s_zero addr=%0d got rd=%h rbusy=%b exp 0/00", tag, a, rd, rbusy);
      else passes++;
    end
  endtask

  task automatic test_bypass();
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    iss_en = 1'b0;
    we = 1'b1; wa = 5'd7; wd = 32'h12345678; ra = {5'd0, 5'd7};
    #1;
    checks++; if (rd[31:0] !== 32'h12345678) $display("FAIL bypass_rd got=%h exp=12345678", rd[31:0]); else passes++;
    checks++; if (rbusy[0] !== 1'b1) $display("FAIL bypass_rbusy got=%b exp=1", rbusy[0]); else passes++;
    tick();
    we = 1'b0;
    #1;
    checks++; if (rbusy[0] !== 1'b0) $display("FAIL bypass_rbusy_next got=%b exp=0", rbusy[0]); else passes++;
    checks++; if (rd[31:0] !== 32'h12345678) $display("FAIL bypass_stored got=%h exp=12345678", rd[31:0]); else passes++;
    checks++; if (werr !== 1'b0) $display("FAIL bypass_werr got=%b exp=0", werr); else passes++;
  endtask

  task automatic test_same_addr_ports();
    ra = {5'd7, 5'd7};
    #1;
    checks++; if (rd[63:32] !== 32'h12345678 || rd[31:0] !== 32'h12345678)
      $display("FAIL dual_port got=%h exp=1234567812345678", rd); else passes++;
  endtask

  task automatic test_iss_we_same();
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    we = 1'b1; wa = 5'd9; wd = 32'h55;
    tick();
    we = 1'b0; iss_en = 1'b0; ra = {5'd0, 5'd9};
    #1;
    checks++; if (rd[31:0] !== 32'h55) $display("FAIL isswe_data got=%h exp=55", rd[31:0]); else passes++;
    checks++; if (rbusy[0] !== 1'b1) $display("FAIL isswe_busy got=%b exp=1", rbusy[0]); else passes++;
    checks++; if (werr !== 1'b0) $display("FAIL isswe_werr got=%b exp=0", werr); else passes++;
  endtask

  task automatic test_multi_iss();
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    tick();
    iss_en = 1'b0;
    #1;
    checks++; if (rbusy[0] !== 1'b1 || werr !== 1'b0)
      $display("FAIL multi_iss got rbusy=%b werr=%b exp 1/0", rbusy[0], werr); else passes++;
  endtask

  task automatic test_zero_werr();
    iss_en = 1'b1; iss_addr = 5'd0;
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra = {5'd0, 5'd0};
    #1;
    checks++; if (rd[31:0] !== 32'd0) $display("FAIL zero_bypass got=%h exp=0", rd[31:0]); else passes++;
    tick();
    we = 1'b0; iss_en = 1'b0;
    #1;
    checks++; if (rd[31:0] !== 32'd0) $display("FAIL zero_stored got=%h exp=0", rd[31:0]); else passes++;
    checks++; if (rbusy !== 2'b00) $display("FAIL zero_rbusy got=%b exp=00", rbusy); else passes++;
    checks++; if (werr !== 1'b0) $display("FAIL zero_werr got=%b exp=0", werr); else passes++;
    we = 1'b1; wa = 5'd4; wd = 32'hA5;
    tick();
    we = 1'b0; ra = {5'd4, 5'd0};
    #1;
    checks++; if (werr !== 1'b1) $display("FAIL werr_set got=%b exp=1", werr); else passes++;
    checks++; if (rd[63:32] !== 32'hA5) $display("FAIL werr_data got=%h exp=a5", rd[63:32]); else passes++;
    repeat (3) tick();
    checks++; if (werr !== 1'b1) $display("FAIL werr_sticky got=%b exp=1", werr); else passes++;
  endtask

  task automatic test_midrun_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b0) $display("FAIL rerst_ready got=%b exp=0", ready); else passes++;
    checks++; if (werr !== 1'b0) $display("FAIL rerst_werr got=%b exp=0", werr); else passes++;
    tick();
    rst_n = 1'b1;
    wait_ready();
    checks++; if (cycles !== 32) $display("FAIL rerst_len got=%0d exp=32", cycles); else passes++;
    test_all_zero("rerst");
  endtask

  initial begin
    test_reset();
    test_clear_ignored();
    test_all_zero("init");
    test_bypass();
    test_same_addr_ports();
    test_iss_we_same();
    test_multi_iss();
    test_zero_werr();
    test_midrun_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
